// File: rtl/bcd_range_counter_if.sv
// Control/data bundle for one BCD counter field; the pm flag exists only
// when BCD_CNT_MERIDIEM_EN is defined.
interface bcd_range_counter_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tc;
    logic       load_err;
`ifdef BCD_CNT_MERIDIEM_EN
    logic       pm;

    modport master (output en, up, load, load_tens, load_ones,
                    input  tens, ones, tc, load_err, pm);
    modport slave  (input  en, up, load, load_tens, load_ones,
                    output tens, ones, tc, load_err, pm);
`else
    modport master (output en, up, load, load_tens, load_ones,
                    input  tens, ones, tc, load_err);
    modport slave  (input  en, up, load, load_tens, load_ones,
                    output tens, ones, tc, load_err);
`endif
endinterface

// File: rtl/bcd_range_counter.sv
// Two-digit BCD up/down counter with programmable range, parallel load and
// registered wrap pulse. Optional meridiem flag under BCD_CNT_MERIDIEM_EN.
module bcd_range_counter #(
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 59,
    parameter int RESET_VAL    = 0,
    parameter int MERIDIEM_VAL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_range_counter_if.slave    bus
);
    localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
    localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);
    localparam logic [3:0] RST_T = 4'(RESET_VAL / 10);
    localparam logic [3:0] RST_O = 4'(RESET_VAL % 10);

    if (MIN_VAL < 0 || MAX_VAL > 99 || MAX_VAL <= MIN_VAL ||
        RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL ||
        MERIDIEM_VAL < 1 || MERIDIEM_VAL > 99) begin : g_bad_param
        $error("bcd_range_counter: illegal parameter combination");
    end

    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic       tc_q, tc_d, load_err_q, load_err_d;
    logic       at_max, at_min, load_ok;
    logic [6:0] load_val;

    assign at_max   = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign at_min   = (tens_q == MIN_T) && (ones_q == MIN_O);
    // Digits are range-checked first, so the 7-bit product cannot alias.
    assign load_val = 7'(7'(bus.load_tens) * 7'd10) + 7'(bus.load_ones);
    assign load_ok  = (bus.load_tens <= 4'd9) && (bus.load_ones <= 4'd9) &&
                      (load_val >= 7'(MIN_VAL)) && (load_val <= 7'(MAX_VAL));

`ifdef BCD_CNT_MERIDIEM_EN
    localparam logic [3:0] MER_T  = 4'(MERIDIEM_VAL / 10);
    localparam logic [3:0] MER_O  = 4'(MERIDIEM_VAL % 10);
    localparam logic [3:0] MERP_T = 4'((MERIDIEM_VAL - 1) / 10);
    localparam logic [3:0] MERP_O = 4'((MERIDIEM_VAL - 1) % 10);
    logic pm_q, pm_d;
    assign bus.pm = pm_q;
`endif

    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
`ifdef BCD_CNT_MERIDIEM_EN
        pm_d       = pm_q;
`endif
        if (bus.load) begin
            if (load_ok) begin
                tens_d = bus.load_tens;
                ones_d = bus.load_ones;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    tens_d = MIN_T;
                    ones_d = MIN_O;
                    tc_d   = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
`ifdef BCD_CNT_MERIDIEM_EN
                // A wrap lands on MIN_VAL, so only a plain step reaches MERIDIEM_VAL.
                if (!at_max && tens_q == MERP_T && ones_q == MERP_O)
                    pm_d = ~pm_q;
`endif
            end else begin
                if (at_min) begin
                    tens_d = MAX_T;
                    ones_d = MAX_O;
                    tc_d   = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
`ifdef BCD_CNT_MERIDIEM_EN
                if (!at_min && tens_q == MER_T && ones_q == MER_O)
                    pm_d = ~pm_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tens_q     <= RST_T;
            ones_q     <= RST_O;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
`ifdef BCD_CNT_MERIDIEM_EN
            pm_q       <= 1'b0;
`endif
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
`ifdef BCD_CNT_MERIDIEM_EN
            pm_q       <= pm_d;
`endif
        end
    end

    assign bus.tens     = tens_q;
    assign bus.ones     = ones_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
endmodule
